// File: rtl/in_xif.sv
// CORE-V-XIF interface types shared by the FPU model and its neighbours.
// Provides the result-channel payload x_result_t and its id width.
package in_xif;

  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_RFW_WIDTH = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic [2:0]             ecswe;
    logic [5:0]             ecsdata;
    logic                   exc;
    logic [5:0]             exccode;
    logic                   err;
    logic                   dbg;
  } x_result_t;

endpackage

// File: rtl/pa_rvfpm.sv
// Configuration constants for the rvfpm FPU model and its attached buffers.
package pa_rvfpm;

  // Number of entries in the result buffer between the FPU and the core.
  localparam int unsigned RESULT_BUF_DEPTH = 4;

endpackage

// File: rtl/rvfpm_fifo_mem.sv
// Register-array storage for small FIFOs: one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
//   ck_i     clock, rising edge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational from raddr_i)
module rvfpm_fifo_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             ck_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge ck_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rvfpm_result_buffer.sv
// Elastic FIFO on the CORE-V-XIF result channel between the FPU model and the
// core. Absorbs results while the core stalls writeback and replays them in
// order. in_ready depends only on registered occupancy (no ready pass-through)
// and there is no in-to-out bypass, so minimum latency is one cycle.
//   ck          clock, rising edge
//   rst         asynchronous reset, active low
//   flush       synchronous clear of all entries (wins over push/pop)
//   in_valid    FPU result valid
//   in_ready    buffer can accept (to FPU result_ready)
//   in_result   FPU result payload
//   out_valid   result valid toward the core
//   out_ready   core accepts the head result
//   out_result  head payload, zero while empty
//   count       current occupancy
//   max_count   high-water mark of count since reset or flush
module rvfpm_result_buffer #(
  parameter int unsigned DEPTH      = pa_rvfpm::RESULT_BUF_DEPTH,
  parameter int unsigned X_ID_WIDTH = in_xif::X_ID_WIDTH,
  parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  in_xif::x_result_t  in_result,
  output logic               out_valid,
  input  logic               out_ready,
  output in_xif::x_result_t  out_result,
  output logic [CNT_W-1:0]   count,
  output logic [CNT_W-1:0]   max_count
);

  localparam int unsigned       AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rvfpm_result_buffer: DEPTH must be a power of two >= 2");
  end
  if (X_ID_WIDTH != in_xif::X_ID_WIDTH) begin : g_bad_id_width
    $error("rvfpm_result_buffer: X_ID_WIDTH differs from x_result_t.id width");
  end
  if (CNT_W < $clog2(DEPTH) + 1) begin : g_bad_cnt_width
    $error("rvfpm_result_buffer: CNT_W too narrow to hold DEPTH");
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic              push, pop;
  in_xif::x_result_t head;

  rvfpm_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(in_xif::x_result_t))
  ) u_mem (
    .ck_i    (ck),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_result),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Full/empty come from the occupancy counter, since equal pointers are
  // ambiguous between the two.
  assign in_ready   = (count_q != FULL_CNT);
  assign out_valid  = (count_q != '0);
  assign out_result = out_valid ? head : '0;
  assign count      = count_q;
  assign max_count  = max_q;

  always_comb begin
    push     = in_valid && in_ready && !flush;
    pop      = out_valid && out_ready && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    max_d    = max_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      max_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
      max_d = (count_d > max_q) ? count_d : max_q;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      max_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
    end
  end

endmodule

// File: tb/tb_rvfpm_result_buffer.sv
// Directed and table-driven checks for rvfpm_result_buffer (DEPTH=4).
module tb_rvfpm_result_buffer;
  import in_xif::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             ck        = 1'b0;
  logic             rst       = 1'b0;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  x_result_t        in_result = '0;
  logic             in_ready;
  logic             out_valid;
  x_result_t        out_result;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] max_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  rvfpm_result_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .ck         (ck),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .count      (count),
    .max_count  (max_count)
  );

  always #5 ck = ~ck;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic x_result_t mk(input logic [3:0] id);
    x_result_t r;
    r         = '0;
    r.id      = id;
    r.data    = {28'hC0DE5A0, id};
    r.rd      = {1'b0, id} + 5'd1;
    r.we      = 1'b1;
    r.ecsdata = {id, 2'b11};
    r.exccode = {2'b00, id};
    return r;
  endfunction

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  typedef struct {
    logic             iv;
    logic [3:0]       id;
    logic             ordy;
    logic             fl;
    logic             e_irdy;
    logic             e_ovld;
    logic [3:0]       e_id;
    logic [CNT_W-1:0] e_cnt;
    logic [CNT_W-1:0] e_max;
  } vec_t;

  vec_t      tbl [17];
  x_result_t sb [$];
  x_result_t sp, exp_r, prev_out;
  logic      prev_stall, hold;
  logic [3:0] next_id;

  initial begin
    //              iv id    ordy fl   irdy ovld hid   cnt  max
    tbl[0]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  3'd1, 3'd1};
    tbl[1]  = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  3'd2, 3'd2};
    tbl[2]  = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  3'd3, 3'd3};
    tbl[3]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  3'd4, 3'd4};
    tbl[4]  = '{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  3'd4, 3'd4};
    tbl[5]  = '{1'b1, 4'd4,  1'b1, 1'b0, 1'b1, 1'b1, 4'd1,  3'd3, 3'd4};
    tbl[6]  = '{1'b1, 4'd4,  1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  3'd3, 3'd4};
    tbl[7]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 4'd3,  3'd2, 3'd4};
    tbl[8]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 4'd4,  3'd1, 3'd4};
    tbl[9]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 3'd4};
    tbl[10] = '{1'b1, 4'd8,  1'b0, 1'b0, 1'b1, 1'b1, 4'd8,  3'd1, 3'd4};
    tbl[11] = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 1'b1, 4'd8,  3'd2, 3'd4};
    tbl[12] = '{1'b1, 4'd10, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8,  3'd3, 3'd4};
    tbl[13] = '{1'b1, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  3'd0, 3'd0};
    tbl[14] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 3'd0};
    tbl[15] = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 3'd1, 3'd1};
    tbl[16] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 3'd1};

    // Reset values while rst is held low
    #2;
    chk("rst_in_ready",   64'(in_ready),   64'd1);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_count",      64'(count),      64'd0);
    chk("rst_max",        64'(max_count),  64'd0);
    #10 rst = 1'b1;
    step();

    // Single result with the core ready
    sp         = '0;
    sp.id      = 4'd3;
    sp.data    = 32'h3F800000;
    sp.rd      = 5'd5;
    in_result  = sp;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    step();
    chk("single_valid",  64'(out_valid),  64'd1);
    chk("single_result", 64'(out_result), 64'(sp));
    chk("single_count",  64'(count),      64'd1);
    in_valid  = 1'b0;
    in_result = '0;
    step();
    chk("single_drain_count", 64'(count),     64'd0);
    chk("single_drain_valid", 64'(out_valid), 64'd0);
    chk("single_max",         64'(max_count), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_clears_max", 64'(max_count), 64'd0);

    // Backpressure fill, in-order drain, flush with occupancy
    for (int unsigned i = 0; i < 17; i++) begin
      in_valid  = tbl[i].iv;
      in_result = mk(tbl[i].id);
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      step();
      exp_r = tbl[i].e_ovld ? mk(tbl[i].e_id) : '0;
      chk($sformatf("vec%0d_in_ready", i),  64'(in_ready),   64'(tbl[i].e_irdy));
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid),  64'(tbl[i].e_ovld));
      chk($sformatf("vec%0d_out_result", i), 64'(out_result), 64'(exp_r));
      chk($sformatf("vec%0d_count", i),     64'(count),      64'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_max", i),       64'(max_count),  64'(tbl[i].e_max));
    end
    flush    = 1'b0;
    in_valid = 1'b0;

    // Steady streaming across pointer wrap-around
    for (int unsigned i = 0; i < 20; i++) begin
      in_valid  = 1'b1;
      in_result = mk(4'(i % 16));
      out_ready = 1'b1;
      step();
      chk($sformatf("stream%0d_count", i),  64'(count),      64'd1);
      chk($sformatf("stream%0d_result", i), 64'(out_result), 64'(mk(4'(i % 16))));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_count", 64'(count),     64'd0);
    chk("stream_max",         64'(max_count), 64'd1);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_result = mk(4'd5);
    step();
    in_result = mk(4'd6);
    step();
    chk("arst_pre_count", 64'(count), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid),  64'd0);
    chk("arst_count",     64'(count),      64'd0);
    chk("arst_in_ready",  64'(in_ready),   64'd1);
    chk("arst_max",       64'(max_count),  64'd0);
    chk("arst_result",    64'(out_result), 64'd0);
    step();
    chk("arst_no_capture", 64'(count), 64'd0);
    rst       = 1'b1;
    in_result = mk(4'd7);
    out_ready = 1'b1;
    step();
    chk("arst_first_valid",  64'(out_valid),  64'd1);
    chk("arst_first_result", 64'(out_result), 64'(mk(4'd7)));
    in_valid = 1'b0;
    step();
    chk("arst_after_count", 64'(count), 64'd0);

    // Randomised stalls against a scoreboard, then a forced drain
    prev_stall = 1'b0;
    prev_out   = '0;
    hold       = 1'b0;
    next_id    = 4'd0;
    for (int unsigned c = 0; c < 1010; c++) begin
      if (prev_stall) begin
        chk("rnd_stable", 64'(out_result), 64'(prev_out));
      end
      chk("rnd_count", 64'(count), 64'(sb.size()));
      chk("rnd_max_bound", 64'(max_count <= 3'd4), 64'd1);
      if (!hold) begin
        in_valid  = (c < 1000) ? ($urandom_range(0, 9) < 6) : 1'b0;
        in_result = mk(next_id);
        in_result.data = $urandom();
      end
      out_ready = (c < 1000) ? ($urandom_range(0, 1) == 1) : 1'b1;
      #2;
      chk("rnd_out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("rnd_spurious_pop", 64'd1, 64'd0);
        end else begin
          chk("rnd_order", 64'(out_result), 64'(sb.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_result);
        next_id = next_id + 4'd1;
      end
      hold       = in_valid && !in_ready;
      prev_stall = out_valid && !out_ready;
      prev_out   = out_result;
      step();
    end
    chk("rnd_drained_sb",    64'(sb.size()), 64'd0);
    chk("rnd_drained_count", 64'(count),     64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
